// File: rtl/barrel_shift_sched_pkg.sv
// barrel_shift_sched_pkg
// Shared definitions for the barrel shift scheduler and its shift core:
// FSM state encoding, shift direction codes and the per-pass step limit.
// No ports; imported by barrel_shift_sched and barrel_shift_core.
package barrel_shift_sched_pkg;

  // Largest shift the core performs in a single pass
  localparam int MAX_STEP = 3;

  // Direction encoding used on req_dir and inside the core
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Scheduler states: waiting for a command, shifting in passes, holding a result
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/barrel_shift_core.sv
// barrel_shift_core
// Purely combinational logical shifter with zero fill, applying one pass
// of 0..3 positions to its data input.
// Ports:
//   data [WIDTH] in  - operand
//   dir          in  - 0 = shift left, 1 = shift right
//   amt  [2]     in  - shift distance for this pass
//   out  [WIDTH] out - shifted operand
module barrel_shift_core
  import barrel_shift_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic [1:0]       amt,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = (dir == DIR_RIGHT) ? (data >> amt) : (data << amt);
  end

endmodule

// File: rtl/barrel_shift_sched.sv
// barrel_shift_sched
// Shares one barrel_shift_core between two requesters. Commands are picked
// round-robin while idle, the total shift is carried out as repeated passes
// of at most MAX_STEP positions, and the result is returned on a
// valid/ready response channel.
// Ports:
//   clk, rst             - clock (rising edge), synchronous active-high reset
//   req_valid/req_ready  - per-requester command handshake (bit i = requester i)
//   req_data             - operands, requester i in bits [i*WIDTH +: WIDTH]
//   req_dir              - per-requester direction (0 left, 1 right)
//   req_amt              - total shift, requester i in bits [i*AMT_W +: AMT_W]
//   rsp_valid/rsp_ready  - result handshake
//   rsp_data, rsp_id     - shifted result and the requester that owns it
//   busy                 - high whenever a command is in flight
module barrel_shift_sched
  import barrel_shift_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_data,
  input  logic [1:0]           req_dir,
  input  logic [2*AMT_W-1:0]   req_amt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_id,
  output logic                 busy
);

  state_t             state;
  state_t             state_nxt;
  logic               rr_ptr;
  logic [WIDTH-1:0]   operand;
  logic               dir_q;
  logic [AMT_W-1:0]   remaining;
  logic               id_q;

  logic [1:0]         grant;
  logic               accept;
  logic               acc_id;
  logic [WIDTH-1:0]   acc_data;
  logic               acc_dir;
  logic [AMT_W-1:0]   acc_amt;
  logic [1:0]         step;
  logic [AMT_W-1:0]   rem_after;
  logic [WIDTH-1:0]   core_out;

  // Round-robin pick: the favoured requester wins if valid, else the other one
  always_comb begin
    grant = 2'b00;
    if (req_valid[rr_ptr]) begin
      grant[rr_ptr] = 1'b1;
    end else if (req_valid[~rr_ptr]) begin
      grant[~rr_ptr] = 1'b1;
    end
  end

  // Select the fields of whichever requester is being accepted
  always_comb begin
    accept   = (state == ST_IDLE) && (grant != 2'b00);
    acc_id   = grant[1];
    acc_data = acc_id ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    acc_dir  = req_dir[acc_id];
    acc_amt  = acc_id ? req_amt[2*AMT_W-1:AMT_W] : req_amt[AMT_W-1:0];
  end

  // Each pass consumes at most MAX_STEP positions of the remaining shift
  always_comb begin
    step      = (remaining >= AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : remaining[1:0];
    rem_after = remaining - {{(AMT_W-2){1'b0}}, step};
  end

  barrel_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data (operand),
    .dir  (dir_q),
    .amt  (step),
    .out  (core_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero-length shift skips straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (acc_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_after == '0) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore-style handshake outputs derived from the current state
  always_comb begin
    req_ready = (state == ST_IDLE) ? grant : 2'b00;
    rsp_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
  end

  // Datapath: latch on accept, shift one pass per SHIFT cycle, and load the
  // response registers only when entering DONE so they hold steady in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      operand   <= '0;
      dir_q     <= DIR_LEFT;
      remaining <= '0;
      id_q      <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            operand   <= acc_data;
            dir_q     <= acc_dir;
            remaining <= acc_amt;
            id_q      <= acc_id;
            rr_ptr    <= ~acc_id;
            if (acc_amt == '0) begin
              rsp_data <= acc_data;
              rsp_id   <= acc_id;
            end
          end
        end
        ST_SHIFT: begin
          operand   <= core_out;
          remaining <= rem_after;
          if (rem_after == '0) begin
            rsp_data <= core_out;
            rsp_id   <= id_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/barrel_shift_sched.md
Name: barrel_shift_sched

Overview:
- Shares one 4-bit logical barrel shifter between two requesters.
- Each request carries a 4-bit operand, a direction and a total shift amount of 0..15.
- The block arbitrates round-robin, then sequences the shift as repeated passes of at most 3 positions each through the core.
- It returns the result on a valid/ready response channel; it sits between command sources and the shared shift datapath.

Parameters:
- WIDTH, 4, operand width; the design is verified only at 4.
- AMT_W, 4, width of the total shift amount per request.
- MAX_STEP, 3, largest shift applied by the core in one pass.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i = requester i presents a command.
- req_ready  out  2  bit i = command from requester i accepted this cycle.
- req_data  in  2*WIDTH  operand; requester i uses bits [i*WIDTH +: WIDTH].
- req_dir  in  2  bit i: 0 = shift left, 1 = shift right.
- req_amt  in  2*AMT_W  total shift amount; requester i uses bits [i*AMT_W +: AMT_W].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH  shifted result.
- rsp_id  out  1  index of the requester that owns rsp_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset values:
  - state = IDLE; rr_ptr = 0, meaning requester 0 is favoured.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
  - req_ready = 0 follows combinationally from the reset state.
- Arbitration, evaluated in IDLE only:
  - grant = the valid requester equal to rr_ptr if it is valid, otherwise the other valid requester.
  - req_ready[i] = (state == IDLE) & grant[i]. This is combinational from req_valid; at most one bit is high.
  - req_ready is 0 in SHIFT and DONE.
- Accept: a handshake happens when req_valid[i] & req_ready[i] in cycle T.
  - Latch operand, dir, amt (remaining = amt) and id = i.
  - Set rr_ptr = ~i.
  - If amt == 0, next state is DONE; otherwise next state is SHIFT.
- SHIFT, once per cycle:
  - step = min(remaining, MAX_STEP).
  - operand <= core(operand, dir, step).
  - remaining <= remaining - step.
  - Go to DONE when remaining - step == 0.
- Shift semantics are logical with zero fill and no rotation. Amounts >= WIDTH give 0, but all passes still execute, so latency is deterministic.
- Latency: rsp_valid rises in cycle T + 1 + ceil(amt/3) (amt 0 -> T+1; amt 15 -> T+6).
- DONE:
  - rsp_valid = 1; rsp_data and rsp_id hold the latched values and stay stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE next cycle; rsp_valid deasserts in that cycle.
  - A new request is not accepted in the same cycle as the response handshake.
- rsp_data and rsp_id keep their last values in IDLE; they are meaningful only while rsp_valid = 1.
- busy = (state != IDLE).
- Inputs on req_* are ignored outside the accept cycle; changing them mid-operation has no effect.
- Reset mid-operation: the in-flight command is discarded, all state returns to reset values the next cycle, and no response is issued.
- rr_ptr changes only on accept, never on reset-free idle cycles.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2;
  - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1;
  - MAX_STEP.
- One sub-module, barrel_shift_core: purely combinational.
  - Ports: data[WIDTH], dir, amt[2] -> out[WIDTH].
  - out = dir ? data >> amt : data << amt, applied to the data input.
  - Instantiated once in the datapath; the FSM, counter and arbiter live in barrel_shift_sched.

Test Plan:
- req0 only: data 0001, dir left, amt 2, accepted at T -> rsp_valid at T+2 with rsp_data 0100, rsp_id 0; busy high T+1..T+2.
- req1 only: data 1101, dir right, amt 5 -> passes of 3 then 2 (0001 then 0000); rsp_data 0000, rsp_id 1, rsp_valid at T+3. Repeat with data 1011, right, amt 15 -> 0000 at T+6.
- amt 0: req0 data 0111, dir right -> rsp_data 0111 at T+1, no SHIFT cycles.
- Both requesters valid continuously from reset, rsp_ready = 1 -> grant order 0,1,0,1; req_ready never has both bits high and is 0 whenever busy = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable, req_ready = 00, busy = 1. Raise rsp_ready -> IDLE next cycle, and the next request is accepted no earlier than the cycle after.
- Assert rst during SHIFT on an amt-9 request -> next cycle IDLE, rsp_valid 0, busy 0, rr_ptr 0; no response is ever produced for that command.
